// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters (port 0: microcode
// sequencer, port 1: auxiliary unit). One operation is accepted per cycle
// through a valid/ready handshake into a registered issue stage that drives
// the ALU directly; the ALU result and flags are captured into a registered
// response stage that is returned to the owning port.
//
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between ports on contention
//   undefined -> fixed priority, port 0 always wins
//
// Ports:
//   clk, reset_n                 core clock, asynchronous active-low reset
//   flush                        discard all in-flight operations
//   req_valid[1:0] / req_ready   per-port request handshake
//   req_a*/req_b*/req_op*        per-port operands and ALU op code
//   req_is_8_bit[1:0]            per-port byte-operation select
//   req_flags*                   per-port flags_in
//   alu_a/alu_b/alu_op/
//   alu_is_8_bit/alu_flags_in    to the shared ALU (zero when issue idle)
//   alu_out/alu_flags_out        from the shared ALU
//   rsp_valid[1:0] / rsp_ready   per-port response handshake
//   rsp_data/rsp_flags           registered result and flags
// -----------------------------------------------------------------------------
`ifndef MC_ALUOp_t_BITS
`define MC_ALUOp_t_BITS 5
`endif

module alu_arbiter #(
    parameter int OP_WIDTH = `MC_ALUOp_t_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [15:0]         req_a0,
    input  logic [15:0]         req_b0,
    input  logic [15:0]         req_a1,
    input  logic [15:0]         req_b1,
    input  logic [OP_WIDTH-1:0] req_op0,
    input  logic [OP_WIDTH-1:0] req_op1,
    input  logic [1:0]          req_is_8_bit,
    input  logic [15:0]         req_flags0,
    input  logic [15:0]         req_flags1,
    output logic [15:0]         alu_a,
    output logic [15:0]         alu_b,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic                alu_is_8_bit,
    output logic [15:0]         alu_flags_in,
    input  logic [15:0]         alu_out,
    input  logic [15:0]         alu_flags_out,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [15:0]         rsp_data,
    output logic [15:0]         rsp_flags
);

    // Issue stage
    logic                iss_valid_q, iss_valid_d;
    logic [15:0]         iss_a_q, iss_a_d;
    logic [15:0]         iss_b_q, iss_b_d;
    logic [OP_WIDTH-1:0] iss_op_q, iss_op_d;
    logic                iss_b8_q, iss_b8_d;
    logic [15:0]         iss_flags_q, iss_flags_d;
    logic                iss_owner_q, iss_owner_d;

    // Result stage
    logic                res_valid_q, res_valid_d;
    logic [15:0]         res_data_q, res_data_d;
    logic [15:0]         res_flags_q, res_flags_d;
    logic                res_owner_q, res_owner_d;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Port served most recently; 1 after reset so port 0 wins first.
    logic                rr_last_q, rr_last_d;
`endif

    logic                drain_s;
    logic                res_adv_s;
    logic                iss_free_s;
    logic                grant_en_s;
    logic [1:0]          grant_s;

    // Pipeline flow control: drain, advance and issue-slot availability.
    always_comb begin
        drain_s = 1'b0;
        if (res_valid_q && !flush) begin
            drain_s = rsp_ready[res_owner_q];
        end else begin
            drain_s = 1'b0;
        end
        res_adv_s  = iss_valid_q & (~res_valid_q | drain_s);
        iss_free_s = ~iss_valid_q | res_adv_s;
        // Reset is folded in so no grant is presented while held in reset.
        grant_en_s = iss_free_s & ~flush & reset_n;
    end

    // Arbitration between the two request ports.
    always_comb begin
        grant_s = 2'b00;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = rr_last_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
`else
        case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b11:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            default: grant_s = 2'b00;
        endcase
`endif
        if (grant_en_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Issue stage next state: load on grant, empty on advance, clear on flush.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_op_d    = iss_op_q;
        iss_b8_d    = iss_b8_q;
        iss_flags_d = iss_flags_q;
        iss_owner_d = iss_owner_q;
        if (flush || (res_adv_s && (req_ready == 2'b00))) begin
            // Payload is zeroed too so the ALU sees all-zero inputs when idle.
            iss_valid_d = 1'b0;
            iss_a_d     = 16'h0000;
            iss_b_d     = 16'h0000;
            iss_op_d    = {OP_WIDTH{1'b0}};
            iss_b8_d    = 1'b0;
            iss_flags_d = 16'h0000;
            iss_owner_d = 1'b0;
        end else if (req_ready != 2'b00) begin
            iss_valid_d = 1'b1;
            iss_owner_d = req_ready[1];
            iss_a_d     = req_ready[1] ? req_a1     : req_a0;
            iss_b_d     = req_ready[1] ? req_b1     : req_b0;
            iss_op_d    = req_ready[1] ? req_op1    : req_op0;
            iss_flags_d = req_ready[1] ? req_flags1 : req_flags0;
            iss_b8_d    = req_ready[1] ? req_is_8_bit[1] : req_is_8_bit[0];
        end else begin
            iss_valid_d = iss_valid_q;
        end
    end

    // Result stage next state: capture ALU output on advance, empty on drain.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_owner_d = res_owner_q;
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (res_adv_s) begin
            // Covers drain-and-reload in the same cycle without a bubble.
            res_valid_d = 1'b1;
            res_data_d  = alu_out;
            res_flags_d = alu_flags_out;
            res_owner_d = iss_owner_q;
        end else if (drain_s) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Round-robin pointer tracks the port of every grant.
    always_comb begin
        if (req_ready != 2'b00) begin
            rr_last_d = req_ready[1];
        end else begin
            rr_last_d = rr_last_q;
        end
    end
`endif

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_valid_q <= 1'b0;
            iss_a_q     <= 16'h0000;
            iss_b_q     <= 16'h0000;
            iss_op_q    <= {OP_WIDTH{1'b0}};
            iss_b8_q    <= 1'b0;
            iss_flags_q <= 16'h0000;
            iss_owner_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
            res_flags_q <= 16'h0000;
            res_owner_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rr_last_q   <= 1'b1;
`endif
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_op_q    <= iss_op_d;
            iss_b8_q    <= iss_b8_d;
            iss_flags_q <= iss_flags_d;
            iss_owner_q <= iss_owner_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_owner_q <= res_owner_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    // Outputs come straight from the stage registers.
    always_comb begin
        alu_a        = iss_a_q;
        alu_b        = iss_b_q;
        alu_op       = iss_op_q;
        alu_is_8_bit = iss_b8_q;
        alu_flags_in = iss_flags_q;
        rsp_data     = res_data_q;
        rsp_flags    = res_flags_q;
        if (res_valid_q) begin
            rsp_valid = res_owner_q ? 2'b10 : 2'b01;
        end else begin
            rsp_valid = 2'b00;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter with directed and random traffic, supplies a simple ALU
// model on the ALU side, and compares every response and every grant against
// a queue-based reference of the arbiter's behaviour.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int OPW = 5;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [15:0]    a;
        logic [15:0]    b;
        logic           b8;
        logic [15:0]    fl;
    } req_t;

    typedef struct {
        int          owner;
        logic [15:0] data;
        logic [15:0] flags;
        int          acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           flush;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [15:0]    req_a0, req_b0, req_a1, req_b1;
    logic [OPW-1:0] req_op0, req_op1;
    logic [1:0]     req_is_8_bit;
    logic [15:0]    req_flags0, req_flags1;
    logic [15:0]    alu_a, alu_b;
    logic [OPW-1:0] alu_op;
    logic           alu_is_8_bit;
    logic [15:0]    alu_flags_in;
    logic [15:0]    alu_out, alu_flags_out;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [15:0]    rsp_data, rsp_flags;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_port = 1;
    int   gnt_cnt0 = 0;
    int   gnt_cnt1 = 0;
    logic [1:0] acc_last = 2'b00;
    exp_t sb[$];

    alu_arbiter #(.OP_WIDTH(OPW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .req_is_8_bit(req_is_8_bit),
        .req_flags0(req_flags0), .req_flags1(req_flags1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_is_8_bit(alu_is_8_bit), .alu_flags_in(alu_flags_in),
        .alu_out(alu_out), .alu_flags_out(alu_flags_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags)
    );

    always #5 clk = ~clk;

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 ADC; others pass a and flags_in.
    // Flags: CF bit 0, ZF bit 6, SF bit 7. Returns {flags, result}.
    function automatic logic [31:0] alu_f(input logic [OPW-1:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic b8,
                                          input logic [15:0] fin);
        logic [16:0] aa, bb, s;
        logic [15:0] r, f;
        aa = b8 ? {9'd0, a[7:0]} : {1'b0, a};
        bb = b8 ? {9'd0, b[7:0]} : {1'b0, b};
        case (op)
            5'd0:    s = aa + bb;
            5'd1:    s = aa - bb;
            5'd2:    s = aa & bb;
            5'd3:    s = aa ^ bb;
            5'd4:    s = aa + bb + {16'd0, fin[0]};
            default: s = {1'b0, a};
        endcase
        f = fin;
        if (op <= 5'd4) begin
            r = b8 ? {8'h00, s[7:0]} : s[15:0];
            f[0] = b8 ? s[8] : s[16];
            f[6] = (r == 16'h0000);
            f[7] = b8 ? r[7] : r[15];
        end else begin
            r = s[15:0];
        end
        return {f, r};
    endfunction

    // ALU stand-in on the ALU side of the arbiter.
    always_comb begin
        {alu_flags_out, alu_out} = alu_f(alu_op, alu_a, alu_b, alu_is_8_bit, alu_flags_in);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.op = OPW'($urandom_range(0, 7));
        r.a  = 16'($urandom);
        r.b  = 16'($urandom);
        r.b8 = 1'($urandom_range(0, 1));
        r.fl = 16'($urandom);
        return r;
    endfunction

    // Apply one cycle of stimulus; a port left waiting keeps its request unchanged.
    task automatic step(input logic [1:0] want, input logic [1:0] rdy, input logic fl,
                        input req_t r0, input req_t r1);
        @(posedge clk);
        #1;
        if (!(req_valid[0] && !acc_last[0])) begin
            req_valid[0] = want[0];
            if (want[0]) begin
                req_op0 = r0.op; req_a0 = r0.a; req_b0 = r0.b;
                req_is_8_bit[0] = r0.b8; req_flags0 = r0.fl;
            end
        end
        if (!(req_valid[1] && !acc_last[1])) begin
            req_valid[1] = want[1];
            if (want[1]) begin
                req_op1 = r1.op; req_a1 = r1.a; req_b1 = r1.b;
                req_is_8_bit[1] = r1.b8; req_flags1 = r1.fl;
            end
        end
        rsp_ready = rdy;
        flush     = fl;
    endtask

    // Monitor and scoreboard: checks outputs each cycle, then advances the reference.
    always @(negedge clk) begin
        logic [1:0] exp_rsp, exp_gnt;
        logic       vis, drain, free;
        logic [31:0] res;
        exp_t       e;
        if (!reset_n) begin
            sb.delete();
            last_port = 1;
            acc_last  = 2'b00;
        end else begin
            vis = (sb.size() > 0) && (sb[0].acc + 1 < cyc);
            exp_rsp = 2'b00;
            if (vis) exp_rsp = (sb[0].owner == 1) ? 2'b10 : 2'b01;
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rsp});
            if (vis) begin
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, sb[0].data});
                chk("rsp_flags", {16'd0, rsp_flags}, {16'd0, sb[0].flags});
            end
            drain = vis && rsp_ready[sb[0].owner] && !flush;
            free  = (sb.size() < 2) || drain;
            exp_gnt = 2'b00;
            if (free && !flush) begin
                if (req_valid == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    exp_gnt = (last_port == 0) ? 2'b10 : 2'b01;
`else
                    exp_gnt = 2'b01;
`endif
                end else begin
                    exp_gnt = req_valid;
                end
            end
            chk("req_ready", {30'd0, req_ready}, {30'd0, exp_gnt});
            gnt_cnt0 += int'(req_ready[0]);
            gnt_cnt1 += int'(req_ready[1]);
            if (flush) begin
                sb.delete();
            end else begin
                if (drain) void'(sb.pop_front());
                if (exp_gnt != 2'b00) begin
                    if (exp_gnt[1])
                        res = alu_f(req_op1, req_a1, req_b1, req_is_8_bit[1], req_flags1);
                    else
                        res = alu_f(req_op0, req_a0, req_b0, req_is_8_bit[0], req_flags0);
                    e.owner = exp_gnt[1] ? 1 : 0;
                    e.data  = res[15:0];
                    e.flags = res[31:16];
                    e.acc   = cyc;
                    sb.push_back(e);
                    last_port = e.owner;
                end
            end
            acc_last = exp_gnt;
            cyc++;
        end
    end

    initial begin
        req_t z, r;
        logic [1:0] w, rd;
        logic fl;
        int g0, g1;
        z = '0;
        reset_n = 1'b0; flush = 1'b0; rsp_ready = 2'b11; req_valid = 2'b11;
        req_a0 = 16'h1234; req_b0 = 16'h5678; req_a1 = 16'h9ABC; req_b1 = 16'hDEF0;
        req_op0 = '0; req_op1 = '0; req_is_8_bit = 2'b00;
        req_flags0 = 16'h0000; req_flags1 = 16'h0000;
        #3;
        chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("reset_rsp_flags", {16'd0, rsp_flags}, 32'd0);
        chk("reset_alu_a", {16'd0, alu_a}, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single 16-bit ADD on port 0.
        r = '{op: 5'd0, a: 16'h00FF, b: 16'h0001, b8: 1'b0, fl: 16'h0000};
        step(2'b01, 2'b11, 1'b0, r, z);
        step(2'b00, 2'b11, 1'b0, z, z);
        step(2'b00, 2'b11, 1'b0, z, z);
        chk("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("add_rsp_data", {16'd0, rsp_data}, 32'h0100);
        chk("add_cf_zf", {30'd0, rsp_flags[6], rsp_flags[0]}, 32'd0);

        // Byte SUB on port 1.
        r = '{op: 5'd1, a: 16'h0000, b: 16'h0001, b8: 1'b1, fl: 16'h0000};
        step(2'b10, 2'b11, 1'b0, z, r);
        step(2'b00, 2'b11, 1'b0, z, z);
        step(2'b00, 2'b11, 1'b0, z, z);
        chk("sub8_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("sub8_rsp_data", {24'd0, rsp_data[7:0]}, 32'h00FF);
        chk("sub8_cf_sf", {30'd0, rsp_flags[7], rsp_flags[0]}, 32'd3);
        step(2'b00, 2'b11, 1'b0, z, z);

        // Contention with both ports always requesting.
        g0 = gnt_cnt0; g1 = gnt_cnt1;
        for (int i = 0; i < 12; i++) step(2'b11, 2'b11, 1'b0, rand_req(), rand_req());
        g0 = gnt_cnt0 - g0; g1 = gnt_cnt1 - g1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        chk("rr_port1_served", {31'd0, g1 >= 5}, 32'd1);
        chk("rr_port0_served", {31'd0, g0 >= 5}, 32'd1);
`else
        chk("fixed_port1_starved", g1, 32'd0);
        chk("fixed_port0_served", {31'd0, g0 >= 10}, 32'd1);
`endif
        for (int i = 0; i < 3; i++) step(2'b00, 2'b11, 1'b0, z, z);

        // Backpressure: three port-0 ADDs while port 0 does not consume.
        for (int i = 0; i < 3; i++) begin
            r = rand_req(); r.op = 5'd0;
            step(2'b01, 2'b10, 1'b0, r, z);
        end
        step(2'b00, 2'b10, 1'b0, z, z);
        for (int i = 0; i < 5; i++) step(2'b00, 2'b11, 1'b0, z, z);

        // Flush with both stages full and a pending port-0 request.
        for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b0, rand_req(), z);
        step(2'b01, 2'b00, 1'b1, rand_req(), z);
        step(2'b00, 2'b11, 1'b0, z, z);
        for (int i = 0; i < 4; i++) step(2'b00, 2'b11, 1'b0, z, z);
        step(2'b01, 2'b11, 1'b0, rand_req(), z);
        for (int i = 0; i < 3; i++) step(2'b00, 2'b11, 1'b0, z, z);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            w  = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            fl = ($urandom_range(0, 31) == 0);
            step(w, rd, fl, rand_req(), rand_req());
        end

        // Asynchronous reset in the middle of traffic, away from any clock edge.
        for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 1'b0, rand_req(), rand_req());
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("async_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("async_alu_a", {16'd0, alu_a}, 32'd0);
        chk("async_req_ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00; flush = 1'b0; rsp_ready = 2'b11;
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            w  = 2'($urandom_range(0, 3));
            rd = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            fl = ($urandom_range(0, 31) == 0);
            step(w, rd, fl, rand_req(), rand_req());
        end

        for (int i = 0; i < 8; i++) step(2'b00, 2'b11, 1'b0, z, z);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
